// File: rtl/axi_lite_cmd_master.sv
// ============================================================================
// Module  : axi_lite_cmd_master
// Brief   : AXI4-Lite master driven by a valid/ready command port, one
//           transaction outstanding, watchdog-bounded, response on a rsp port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module axi_lite_cmd_master #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_TIMEOUT        = 256
) (
  input  logic                          clock_axi,
  input  logic                          reset_axi,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rnw,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int WD_W   = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'((C_TIMEOUT > 0) ? C_TIMEOUT : 0);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RESP         = 3'd5
  } state_t;

  state_t                        state_q;
  logic                          cmd_ready_q;
  logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          bready_q;
  logic                          arvalid_q;
  logic                          rready_q;
  logic                          rsp_valid_q;
  logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                    rsp_resp_q;
  logic                          rsp_timeout_q;
  logic [WD_W-1:0]               wdog_q;
  logic [WD_W-1:0]               wdog_d;

  logic w_aw_done;
  logic w_w_done;
  logic w_complete;
  logic w_active;
  logic w_expire;

  // A channel counts as done once its valid has been retired or is being accepted now.
  always_comb begin
    w_aw_done  = !awvalid_q || m_axi_awready;
    w_w_done   = !wvalid_q  || m_axi_wready;
    w_complete = 1'b0;
    case (state_q)
      S_WR_ADDR_DATA: w_complete = w_aw_done && w_w_done;
      S_WR_RESP:      w_complete = m_axi_bvalid && bready_q;
      S_RD_ADDR:      w_complete = arvalid_q && m_axi_arready;
      S_RD_DATA:      w_complete = m_axi_rvalid && rready_q;
      default:        w_complete = 1'b0;
    endcase
  end

  assign w_active = (state_q != S_IDLE) && (state_q != S_RESP);
  assign w_expire = (C_TIMEOUT > 0) && w_active && (wdog_q == WD_LAST);
  assign wdog_d   = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WD_W'(1);

  always_ff @(posedge clock_axi) begin
    if (reset_axi) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      if (w_active) begin
        wdog_q <= wdog_d;
      end
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            wdog_q      <= '0;
            if (cmd_rnw) begin
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_ADDR_DATA;
            end
          end
        end
        S_WR_ADDR_DATA: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (w_complete) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (w_complete) begin
            bready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= m_axi_bresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RD_ADDR: begin
          if (w_complete) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_complete) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= m_axi_rdata;
            rsp_resp_q    <= m_axi_rresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Watchdog abort overrides the per-state updates; a same-cycle completion wins.
      if (w_expire && !w_complete) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        bready_q      <= 1'b0;
        rready_q      <= 1'b0;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= 2'b10;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state_q       <= S_RESP;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
// ============================================================================
// Module  : tb_axi_lite_cmd_master
// Brief   : Scoreboard bench for axi_lite_cmd_master with a configurable
//           register-file slave and a high-level reference memory model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_cmd_master;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  axi_lite_cmd_master #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .C_TIMEOUT(TMO)
  ) dut (
    .clock_axi(clk), .reset_axi(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Slave: 4-word register file, misaligned addresses answer SLVERR, hang = never ready.
  int sl_aw_dly = 0, sl_w_dly = 0, sl_b_dly = 0, sl_ar_dly = 0, sl_r_dly = 0;
  bit sl_hang = 1'b0;
  bit aw_got, w_got, ar_got;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_mem [4];

  initial for (int i = 0; i < 4; i++) s_mem[i] = '0;

  assign m_axi_awready = !sl_hang && m_axi_awvalid && !aw_got && (aw_cnt >= sl_aw_dly);
  assign m_axi_wready  = !sl_hang && m_axi_wvalid  && !w_got  && (w_cnt  >= sl_w_dly);
  assign m_axi_arready = !sl_hang && m_axi_arvalid && !ar_got && (ar_cnt >= sl_ar_dly);

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      m_axi_bvalid <= 0; m_axi_bresp <= 0;
      m_axi_rvalid <= 0; m_axi_rresp <= 0; m_axi_rdata <= 0;
    end else begin
      if (!m_axi_awvalid) aw_cnt <= 0;
      else if (!aw_got) begin
        if (m_axi_awready) begin aw_got <= 1; s_awaddr <= m_axi_awaddr; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (!m_axi_wvalid) w_cnt <= 0;
      else if (!w_got) begin
        if (m_axi_wready) begin w_got <= 1; s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !m_axi_bvalid) begin
        if (b_cnt >= sl_b_dly) begin
          m_axi_bvalid <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
          if (s_awaddr[1:0] == 2'b00) begin
            m_axi_bresp <= 2'b00;
            for (int i = 0; i < SW; i++)
              if (s_wstrb[i]) s_mem[s_awaddr[3:2]][i*8 +: 8] <= s_wdata[i*8 +: 8];
          end else m_axi_bresp <= 2'b10;
        end else b_cnt <= b_cnt + 1;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 0;
      if (!m_axi_arvalid) ar_cnt <= 0;
      else if (!ar_got) begin
        if (m_axi_arready) begin ar_got <= 1; s_araddr <= m_axi_araddr; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (ar_got && !m_axi_rvalid) begin
        if (r_cnt >= sl_r_dly) begin
          m_axi_rvalid <= 1; r_cnt <= 0; ar_got <= 0;
          m_axi_rdata  <= (s_araddr[1:0] == 2'b00) ? s_mem[s_araddr[3:2]] : '0;
          m_axi_rresp  <= (s_araddr[1:0] == 2'b00) ? 2'b00 : 2'b10;
        end else r_cnt <= r_cnt + 1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
    end
  end

  // Per-transaction handshake counts, accept timestamp, and held-valid tracking.
  int cyc = 0, acc_cycle = 0;
  logic [3:0] n_aw, n_w, n_b, n_ar, n_r;
  logic pend_aw, pend_w, pend_ar;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cycle <= cyc;
      n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) n_aw <= n_aw + 1;
      if (m_axi_wvalid && m_axi_wready)   n_w  <= n_w + 1;
      if (m_axi_bvalid && m_axi_bready)   n_b  <= n_b + 1;
      if (m_axi_arvalid && m_axi_arready) n_ar <= n_ar + 1;
      if (m_axi_rvalid && m_axi_rready)   n_r  <= n_r + 1;
    end
    pend_aw <= !rst && m_axi_awvalid && !m_axi_awready;
    pend_w  <= !rst && m_axi_wvalid && !m_axi_wready;
    pend_ar <= !rst && m_axi_arvalid && !m_axi_arready;
    prev_awaddr <= m_axi_awaddr; prev_araddr <= m_axi_araddr; prev_wdata <= m_axi_wdata;
  end

  always @(negedge clk) begin
    if (!rst && !rsp_valid && (pend_aw || pend_w || pend_ar))
      check("valid_hold",
            {pend_aw & m_axi_awvalid, pend_w & m_axi_wvalid, pend_ar & m_axi_arvalid,
             m_axi_awaddr, m_axi_araddr, m_axi_wdata},
            {pend_aw, pend_w, pend_ar, prev_awaddr, prev_araddr, prev_wdata});
  end

  // Reference model: plain memory plus expected-response queue.
  typedef struct {
    bit         timeout;
    logic [1:0] resp;
    logic [DW-1:0] rdata;
    logic [19:0] cnts;
    int         hold;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [4];
  int force_hold = -1;
  bit in_rsp = 0;

  initial for (int i = 0; i < 4; i++) ref_mem[i] = '0;

  initial begin : monitor
    exp_t e;
    int hold;
    logic [DW-1:0] sv_rdata;
    logic [1:0] sv_resp;
    logic sv_to;
    hold = 0; sv_rdata = '0; sv_resp = '0; sv_to = 0;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 0; rsp_ready = 0;
      end else begin
        if (in_rsp && rsp_ready) begin
          in_rsp = 0; rsp_ready = 0;
          check("cmd_ready_after_rsp", cmd_ready, 1);
          check("rsp_valid_drop", rsp_valid, 0);
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1;
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
              hold = 0;
            end else begin
              e = exp_q.pop_front();
              check("rsp_rdata", rsp_rdata, e.rdata);
              check("rsp_resp", rsp_resp, e.resp);
              check("rsp_timeout", rsp_timeout, e.timeout);
              check("handshakes", {n_aw, n_w, n_b, n_ar, n_r}, e.cnts);
              if (e.timeout) check("timeout_latency", cyc - acc_cycle - 1, TMO);
              hold = e.hold;
            end
            sv_rdata = rsp_rdata; sv_resp = rsp_resp; sv_to = rsp_timeout;
          end else begin
            check("rsp_stable", {rsp_rdata, rsp_resp, rsp_timeout}, {sv_rdata, sv_resp, sv_to});
            check("cmd_ready_in_rsp", cmd_ready, 0);
          end
          check("axi_quiet_in_rsp",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
          if (hold == 0) rsp_ready = 1;
          else hold--;
        end
      end
    end
  end

  task automatic issue(input bit rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input bit hang,
                       input int awd, input int wd, input int bd, input int ard, input int rd);
    exp_t e;
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait actual=0 required=1");
      return;
    end
    sl_hang = hang; sl_aw_dly = awd; sl_w_dly = wd; sl_b_dly = bd; sl_ar_dly = ard; sl_r_dly = rd;
    e.hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
    e.rdata = '0;
    if (hang) begin
      e.timeout = 1; e.resp = 2'b10; e.cnts = '0;
    end else begin
      e.timeout = 0;
      e.cnts = rnw ? 20'h00011 : 20'h11100;
      if (a[1:0] != 2'b00) e.resp = 2'b10;
      else begin
        e.resp = 2'b00;
        if (rnw) e.rdata = ref_mem[a[3:2]];
        else for (int i = 0; i < SW; i++) if (s[i]) ref_mem[a[3:2]][i*8 +: 8] = d[i*8 +: 8];
      end
    end
    exp_q.push_back(e);
    cmd_valid = 1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  initial begin : stimulus
    int w;
    rst = 1; cmd_valid = 0; cmd_rnw = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                         m_axi_rready, rsp_valid, rsp_timeout}, 0);
    check("reset_data", {rsp_rdata, rsp_resp, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    rst = 0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    issue(0, 4'h0, 32'h0000_000F, 4'hF, 0, 0, 0, 0, 0, 0);
    issue(0, 4'h0, 32'h0000_000A, 4'hF, 0, 0, 0, 0, 0, 0);
    issue(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    issue(0, 4'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 3, 1, 0, 0);
    issue(0, 4'h4, 32'h1234_5678, 4'h5, 0, 3, 0, 0, 0, 0);
    issue(1, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2);
    issue(1, 4'h8, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0);
    issue(0, 4'h6, 32'h5555_5555, 4'hF, 0, 0, 0, 0, 0, 0);
    force_hold = 5;
    issue(0, 4'h0, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0);
    force_hold = 0;
    issue(0, 4'h0, 32'h2, 4'hF, 0, 0, 0, 0, 0, 0);
    force_hold = -1;
    issue(1, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a write: no response may follow.
    w = 0;
    while ((exp_q.size() != 0 || in_rsp) && w < 200) begin @(negedge clk); w++; end
    issue(0, 4'hC, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("awvalid_before_reset", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    rst = 1;
    @(negedge clk);
    exp_q.delete();
    check("reset_abort", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                          m_axi_rready, rsp_valid, cmd_ready}, 0);
    rst = 0; sl_hang = 0;
    @(negedge clk);
    check("cmd_ready_after_abort", cmd_ready, 1);

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 5) == 0) ? AW'($urandom) : {2'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(1'($urandom), a, $urandom, SW'($urandom), ($urandom_range(0, 9) == 0),
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 3));
    end

    w = 0;
    while ((exp_q.size() != 0 || in_rsp) && w < 400) begin @(negedge clk); w++; end
    if (exp_q.size() != 0 || in_rsp) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
